// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//  Shared definitions for the EC413 CPU pipeline stages.
//  Holds the datapath width, opcode constants, instruction field positions,
//  the next-PC source enumeration used by fetch, and a sign-extension helper.
//  No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN = 32;

   // Opcodes that the front end cares about; the rest are decoded downstream.
   localparam logic [5:0] OP_J   = 6'b000001;
   localparam logic [5:0] OP_JAL = 6'b000010;
   localparam logic [5:0] OP_BNE = 6'b000100;
   localparam logic [5:0] OP_BEQ = 6'b000101;

   // Instruction field slice positions.
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   // Source selected for the next PC value.
   typedef enum logic [1:0] {
      NPC_SEQ,
      NPC_JUMP,
      NPC_HOLD,
      NPC_REDIRECT
   } npc_sel_e;

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
      return {{(XLEN-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// ----------------------------------------------------------------------------
// fetch_next_pc
//  Combinational next-PC selection for the fetch stage, including early
//  decode of J/JAL so the jump target is fetched on the very next edge.
//  Ports:
//   pc_i           current PC (word index)
//   opcode_i       opcode field of the word fetched at pc_i
//   imm_i          16-bit immediate of the word fetched at pc_i
//   stall_i        hold the PC
//   redirect_i     downstream branch taken
//   redirect_pc_i  branch target
//   next_pc_o      PC value for the next edge
//   jmp_o          the fetched word is a J/JAL being redirected in fetch
// ----------------------------------------------------------------------------
module fetch_next_pc #(
   parameter logic [5:0] OP_J       = cpu_pkg::OP_J,
   parameter logic [5:0] OP_JAL     = cpu_pkg::OP_JAL,
   parameter bit         EARLY_JUMP = 1'b1
) (
   input  logic [cpu_pkg::XLEN-1:0] pc_i,
   input  logic [5:0]               opcode_i,
   input  logic [15:0]              imm_i,
   input  logic                     stall_i,
   input  logic                     redirect_i,
   input  logic [cpu_pkg::XLEN-1:0] redirect_pc_i,
   output logic [cpu_pkg::XLEN-1:0] next_pc_o,
   output logic                     jmp_o
);
   import cpu_pkg::*;

   npc_sel_e        sel;
   logic [XLEN-1:0] pc_plus1;
   logic [XLEN-1:0] jump_target;
   logic            is_jump_op;

   // A jump only counts when the word is actually being accepted this edge:
   // a redirect or stall means the word at pc_i is not moving forward, so its
   // opcode must not steer the PC. Redirect beats stall so a resolved branch
   // is never dropped. Additions wrap naturally at 2^32.
   always_comb begin
      pc_plus1    = pc_i + 32'd1;
      jump_target = pc_plus1 + sext16(imm_i);
      is_jump_op  = (opcode_i == OP_J) || (opcode_i == OP_JAL);
      jmp_o       = EARLY_JUMP && is_jump_op && !redirect_i && !stall_i;

      if (redirect_i) begin
         sel = NPC_REDIRECT;
      end else if (stall_i) begin
         sel = NPC_HOLD;
      end else if (jmp_o) begin
         sel = NPC_JUMP;
      end else begin
         sel = NPC_SEQ;
      end

      case (sel)
         NPC_REDIRECT: next_pc_o = redirect_pc_i;
         NPC_HOLD:     next_pc_o = pc_i;
         NPC_JUMP:     next_pc_o = jump_target;
         NPC_SEQ:      next_pc_o = pc_plus1;
         default:      next_pc_o = pc_plus1;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//  Instruction-fetch stage of the EC413 CPU. Owns the PC, presents it to
//  instruction memory, and captures the returned word into IF/ID. J/JAL are
//  redirected early; branches, stalls and flushes arrive from downstream.
//  The PC is a word index.
//  Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   stall_i          hold PC and IF/ID
//   flush_i          invalidate IF/ID on this edge
//   redirect_i       downstream branch taken, target on redirect_pc_i
//   imem_pc_o        instruction memory address (the PC register)
//   imem_instr_i     combinational instruction word for imem_pc_o
//   ifid_instr_o     registered instruction
//   ifid_pc_o        PC of ifid_instr_o
//   ifid_pc1_o       ifid_pc_o+1, link value for JAL
//   ifid_valid_o     IF/ID holds a live instruction
//   fetch_cnt_o      number of instructions accepted into IF/ID
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [5:0]  OP_J       = cpu_pkg::OP_J,
   parameter logic [5:0]  OP_JAL     = cpu_pkg::OP_JAL,
   parameter bit          EARLY_JUMP = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     redirect_i,
   input  logic [cpu_pkg::XLEN-1:0] redirect_pc_i,
   output logic [cpu_pkg::XLEN-1:0] imem_pc_o,
   input  logic [cpu_pkg::XLEN-1:0] imem_instr_i,
   output logic [cpu_pkg::XLEN-1:0] ifid_instr_o,
   output logic [cpu_pkg::XLEN-1:0] ifid_pc_o,
   output logic [cpu_pkg::XLEN-1:0] ifid_pc1_o,
   output logic                     ifid_valid_o,
   output logic [cpu_pkg::XLEN-1:0] fetch_cnt_o
);
   import cpu_pkg::*;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0] ifid_pc1_q, ifid_pc1_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
   logic            jmp;

   fetch_next_pc #(
      .OP_J       (OP_J),
      .OP_JAL     (OP_JAL),
      .EARLY_JUMP (EARLY_JUMP)
   ) u_next_pc (
      .pc_i          (pc_q),
      .opcode_i      (imem_instr_i[OPC_MSB:OPC_LSB]),
      .imm_i         (imem_instr_i[IMM_MSB:IMM_LSB]),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .next_pc_o     (pc_d),
      .jmp_o         (jmp)
   );

   // IF/ID capture. A redirect or flush kills the slot but leaves the data
   // fields untouched; a jump word itself is captured valid so JAL can link
   // from ifid_pc1.
   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc1_d   = ifid_pc1_q;
      ifid_valid_d = ifid_valid_q;
      fetch_cnt_d  = fetch_cnt_q;
      if (redirect_i || flush_i) begin
         ifid_valid_d = 1'b0;
      end else if (!stall_i) begin
         ifid_instr_d = imem_instr_i;
         ifid_pc_d    = pc_q;
         ifid_pc1_d   = pc_q + 32'd1;
         ifid_valid_d = 1'b1;
         fetch_cnt_d  = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_pc1_q   <= '0;
         ifid_valid_q <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc1_q   <= ifid_pc1_d;
         ifid_valid_q <= ifid_valid_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   // Early jumps are only ever taken on an edge where the word is accepted.
   jmp_only_when_accepted: assert property (@(posedge clk) disable iff (!rst_n)
      jmp |-> (!stall_i && !redirect_i));

   assign imem_pc_o    = pc_q;
   assign ifid_instr_o = ifid_instr_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign ifid_pc1_o   = ifid_pc1_q;
   assign ifid_valid_o = ifid_valid_q;
   assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//  Self-checking bench for fetch_stage. Two instances share the stimulus:
//  index 0 has early jumps enabled, index 1 fetches sequentially through
//  J/JAL. A word-indexed instruction memory model feeds both.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, redirect;
   logic [31:0] rpc;

   logic [31:0] dut_pc[2];
   logic [31:0] dut_imem[2];
   logic [31:0] dut_iinstr[2];
   logic [31:0] dut_ipc[2];
   logic [31:0] dut_ipc1[2];
   logic        dut_valid[2];
   logic [31:0] dut_cnt[2];

   logic [31:0] prog[64];

   // Reference state: PC and the IF/ID contents as the rules dictate.
   logic [31:0] m_pc[2];
   logic [31:0] m_instr[2];
   logic [31:0] m_ipc[2];
   logic        m_valid[2];
   logic [31:0] m_cnt[2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Program area is 64 words; beyond it memory returns a non-jump filler.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd64) return prog[a[5:0]];
      return {6'h3F, a[25:0]};
   endfunction

   always_comb dut_imem[0] = mem_word(dut_pc[0]);
   always_comb dut_imem[1] = mem_word(dut_pc[1]);

   fetch_stage #(.RESET_PC(32'd0), .OP_J(6'b000001), .OP_JAL(6'b000010), .EARLY_JUMP(1'b1)) dut_early (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(rpc),
      .imem_pc_o(dut_pc[0]), .imem_instr_i(dut_imem[0]),
      .ifid_instr_o(dut_iinstr[0]), .ifid_pc_o(dut_ipc[0]), .ifid_pc1_o(dut_ipc1[0]),
      .ifid_valid_o(dut_valid[0]), .fetch_cnt_o(dut_cnt[0])
   );

   fetch_stage #(.RESET_PC(32'd0), .OP_J(6'b000001), .OP_JAL(6'b000010), .EARLY_JUMP(1'b0)) dut_seq (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(rpc),
      .imem_pc_o(dut_pc[1]), .imem_instr_i(dut_imem[1]),
      .ifid_instr_o(dut_iinstr[1]), .ifid_pc_o(dut_ipc[1]), .ifid_pc1_o(dut_ipc1[1]),
      .ifid_valid_o(dut_valid[1]), .fetch_cnt_o(dut_cnt[1])
   );

   task automatic load_program();
      for (int i = 0; i < 64; i++) begin
         prog[i] = {6'($urandom_range(3, 63)), 26'($urandom)};
      end
      prog[0]  = 32'hE400FFFF;
      prog[18] = {6'b000001, 10'd0, 16'h0002};
      prog[30] = {6'b000010, 10'd0, 16'hFFEC};
      prog[40] = {6'b000001, 10'd0, 16'hFFF0};
      prog[50] = {6'b000001, 10'd0, 16'h7FFF};
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'd0; m_instr[k] = 32'd0; m_ipc[k] = 32'd0;
         m_valid[k] = 1'b0; m_cnt[k] = 32'd0;
      end
   endtask

   // One clock edge of the reference, evaluated from the current inputs.
   task automatic model_step();
      logic [31:0] w, nxt;
      bit          take_jump;
      for (int k = 0; k < 2; k++) begin
         w = mem_word(m_pc[k]);
         take_jump = (k == 0) && !redirect && !stall &&
                     (w[31:26] == 6'b000001 || w[31:26] == 6'b000010);
         if (redirect)       nxt = rpc;
         else if (stall)     nxt = m_pc[k];
         else if (take_jump) nxt = m_pc[k] + 32'd1 + {{16{w[15]}}, w[15:0]};
         else                nxt = m_pc[k] + 32'd1;
         if (redirect || flush) begin
            m_valid[k] = 1'b0;
         end else if (!stall) begin
            m_instr[k] = w; m_ipc[k] = m_pc[k]; m_valid[k] = 1'b1;
            m_cnt[k] = m_cnt[k] + 32'd1;
         end
         m_pc[k] = nxt;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 0; flush = 0; redirect = 0; rpc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dut_pc[0] !== 32'd0) begin failures++; $display("[TB] FAIL rst_pc: got %h want %h", dut_pc[0], 32'd0); end
      checks++; if (dut_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b want 0", dut_valid[0]); end
      checks++; if ({dut_iinstr[0], dut_ipc[0], dut_ipc1[0], dut_cnt[0]} !== 128'd0) begin failures++;
         $display("[TB] FAIL rst_fields: got %h %h %h %h want all zero", dut_iinstr[0], dut_ipc[0], dut_ipc1[0], dut_cnt[0]); end
      rst_n = 1'b1;
      tick();
      checks++; if (dut_ipc[0] !== 32'd0) begin failures++; $display("[TB] FAIL t1_ifid_pc: got %h want 0", dut_ipc[0]); end
      checks++; if (dut_iinstr[0] !== 32'hE400FFFF) begin failures++; $display("[TB] FAIL t1_instr: got %h want e400ffff", dut_iinstr[0]); end
      checks++; if (dut_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL t1_valid: got %b want 1", dut_valid[0]); end
      checks++; if (dut_pc[0] !== 32'd1) begin failures++; $display("[TB] FAIL t1_imem_pc: got %h want 1", dut_pc[0]); end
      repeat (5) tick();
      checks++; if (dut_cnt[0] !== 32'd6) begin failures++; $display("[TB] FAIL t1_cnt: got %0d want 6", dut_cnt[0]); end
   endtask

   task automatic test_early_jump();
      // ifid_pc is 5 here; 13 more edges bring PC 18 into IF/ID.
      repeat (13) tick();
      checks++; if (dut_ipc[0] !== 32'd18 || dut_ipc[1] !== 32'd18) begin failures++;
         $display("[TB] FAIL t2_at18: got %0d/%0d want 18/18", dut_ipc[0], dut_ipc[1]); end
      checks++; if (dut_iinstr[0] !== 32'h04000002 || dut_valid[0] !== 1'b1) begin failures++;
         $display("[TB] FAIL t2_jword: got %h v=%b want 04000002 v=1", dut_iinstr[0], dut_valid[0]); end
      tick();
      checks++; if (dut_ipc[0] !== 32'd21 || dut_valid[0] !== 1'b1) begin failures++;
         $display("[TB] FAIL t2_early_2nd: got %0d v=%b want 21 v=1", dut_ipc[0], dut_valid[0]); end
      checks++; if (dut_ipc[1] !== 32'd19) begin failures++; $display("[TB] FAIL t2_seq_2nd: got %0d want 19", dut_ipc[1]); end
      tick();
      checks++; if (dut_ipc[0] !== 32'd22 || dut_valid[0] !== 1'b1) begin failures++;
         $display("[TB] FAIL t2_early_3rd: got %0d v=%b want 22 v=1", dut_ipc[0], dut_valid[0]); end
      checks++; if (dut_ipc[1] !== 32'd20) begin failures++; $display("[TB] FAIL t2_seq_3rd: got %0d want 20", dut_ipc[1]); end
   endtask

   task automatic test_branch();
      redirect = 1; rpc = 32'd13; tick();
      redirect = 0; tick();
      checks++; if (dut_ipc[0] !== 32'd13) begin failures++; $display("[TB] FAIL t3_setup: got %0d want 13", dut_ipc[0]); end
      redirect = 1; rpc = 32'd10; tick();
      checks++; if (dut_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL t3_kill: got %b want 0", dut_valid[0]); end
      checks++; if (dut_pc[0] !== 32'd10) begin failures++; $display("[TB] FAIL t3_imem_pc: got %0d want 10", dut_pc[0]); end
      redirect = 0; tick();
      checks++; if (dut_ipc[0] !== 32'd10 || dut_valid[0] !== 1'b1) begin failures++;
         $display("[TB] FAIL t3_target: got %0d v=%b want 10 v=1", dut_ipc[0], dut_valid[0]); end
      checks++; if (dut_ipc1[0] !== 32'd11) begin failures++; $display("[TB] FAIL t3_pc1: got %0d want 11", dut_ipc1[0]); end
   endtask

   task automatic test_stall();
      logic [31:0] frozen;
      redirect = 1; rpc = 32'd4; tick();
      redirect = 0; tick();
      frozen = m_cnt[0];
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (dut_pc[0] !== 32'd5 || dut_ipc[0] !== 32'd4) begin failures++;
            $display("[TB] FAIL t4_hold%0d: got pc=%0d ifid=%0d want 5/4", i, dut_pc[0], dut_ipc[0]); end
         checks++; if (dut_cnt[0] !== frozen || dut_valid[0] !== 1'b1) begin failures++;
            $display("[TB] FAIL t4_cnt%0d: got %0d v=%b want %0d v=1", i, dut_cnt[0], dut_valid[0], frozen); end
      end
      stall = 0; tick();
      checks++; if (dut_ipc[0] !== 32'd5 || dut_pc[0] !== 32'd6) begin failures++;
         $display("[TB] FAIL t4_release: got ifid=%0d pc=%0d want 5/6", dut_ipc[0], dut_pc[0]); end
   endtask

   task automatic test_simultaneous();
      stall = 1; redirect = 1; rpc = 32'd2; tick();
      checks++; if (dut_pc[0] !== 32'd2 || dut_valid[0] !== 1'b0) begin failures++;
         $display("[TB] FAIL t5_stall_redir: got pc=%0d v=%b want 2 v=0", dut_pc[0], dut_valid[0]); end
      stall = 0; redirect = 0; tick();
      checks++; if (dut_ipc[0] !== 32'd2 || dut_pc[0] !== 32'd3) begin failures++;
         $display("[TB] FAIL t5_after_redir: got ifid=%0d pc=%0d want 2/3", dut_ipc[0], dut_pc[0]); end
      stall = 1; flush = 1; tick();
      checks++; if (dut_pc[0] !== 32'd3 || dut_valid[0] !== 1'b0) begin failures++;
         $display("[TB] FAIL t5_stall_flush: got pc=%0d v=%b want 3 v=0", dut_pc[0], dut_valid[0]); end
      stall = 0; flush = 0; tick();
      checks++; if (dut_ipc[0] !== 32'd3 || dut_valid[0] !== 1'b1) begin failures++;
         $display("[TB] FAIL t5_after_flush: got ifid=%0d v=%b want 3 v=1", dut_ipc[0], dut_valid[0]); end
   endtask

   task automatic test_corners();
      redirect = 1; rpc = 32'hFFFFFFFF; tick();
      checks++; if (dut_pc[0] !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL t6_top: got %h want ffffffff", dut_pc[0]); end
      redirect = 0; tick();
      checks++; if (dut_pc[0] !== 32'd0 || dut_ipc[0] !== 32'hFFFFFFFF) begin failures++;
         $display("[TB] FAIL t6_wrap: got pc=%h ifid=%h want 0/ffffffff", dut_pc[0], dut_ipc[0]); end
      checks++; if (dut_ipc1[0] !== 32'd0) begin failures++; $display("[TB] FAIL t6_pc1_wrap: got %h want 0", dut_ipc1[0]); end
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (dut_pc[0] !== 32'd0 || dut_valid[0] !== 1'b0) begin failures++;
         $display("[TB] FAIL t6_async_rst: got pc=%h v=%b want 0 v=0", dut_pc[0], dut_valid[0]); end
      checks++; if ({dut_iinstr[0], dut_ipc[0], dut_ipc1[0], dut_cnt[0]} !== 128'd0) begin failures++;
         $display("[TB] FAIL t6_rst_fields: got %h %h %h %h want all zero", dut_iinstr[0], dut_ipc[0], dut_ipc1[0], dut_cnt[0]); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      checks++; if (dut_iinstr[0] !== 32'hE400FFFF || dut_cnt[0] !== 32'd1 || dut_pc[0] !== 32'd1) begin failures++;
         $display("[TB] FAIL t6_restart: got %h cnt=%0d pc=%0d want e400ffff 1 1", dut_iinstr[0], dut_cnt[0], dut_pc[0]); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         stall    = ($urandom_range(0, 99) < 20);
         flush    = ($urandom_range(0, 99) < 8);
         redirect = ($urandom_range(0, 99) < 8);
         rpc      = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 63));
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++; if (dut_pc[k] !== m_pc[k]) begin failures++;
               $display("[TB] FAIL rnd_pc[%0d] cyc %0d: got %h want %h", k, n, dut_pc[k], m_pc[k]); end
            checks++; if (dut_valid[k] !== m_valid[k]) begin failures++;
               $display("[TB] FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, n, dut_valid[k], m_valid[k]); end
            checks++; if (dut_cnt[k] !== m_cnt[k]) begin failures++;
               $display("[TB] FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d", k, n, dut_cnt[k], m_cnt[k]); end
            if (m_valid[k]) begin
               checks++; if (dut_iinstr[k] !== m_instr[k] || dut_ipc[k] !== m_ipc[k] || dut_ipc1[k] !== m_ipc[k] + 32'd1) begin
                  failures++;
                  $display("[TB] FAIL rnd_ifid[%0d] cyc %0d: got %h/%h/%h want %h/%h/%h", k, n,
                           dut_iinstr[k], dut_ipc[k], dut_ipc1[k], m_instr[k], m_ipc[k], m_ipc[k] + 32'd1);
               end
            end
         end
      end
      stall = 0; flush = 0; redirect = 0;
   endtask

   initial begin
      load_program();
      test_reset();
      test_early_jump();
      test_branch();
      test_stall();
      test_simultaneous();
      test_corners();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
